board_mem: RTL and testbench
============================

Name: board_mem

Overview:
- Cell-grid storage for the playfield: ROWS x COLS cells of CW bits each.
- Written by game logic; read once per pixel by the downstream pixel generator, which converts h_cnt/v_cnt into a cell index (x = column, y = row, y = 0 is the top row).
- Contains a line-clear engine. When started, it removes every full row, shifts the rows above it down, and reports how many rows it removed.

Parameters:
- COLS, 10, number of columns (x range 0..COLS-1)
- ROWS, 10, number of rows (y range 0..ROWS-1)
- CW, 2, bits per cell; value 0 = empty, nonzero = occupied/colour

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- wr_en  input  1  cell write strobe
- wr_x  input  4  write column
- wr_y  input  4  write row
- wr_data  input  CW  value to write
- rd_x  input  4  read column (from pixel generator)
- rd_y  input  4  read row
- rd_data  output  CW  registered cell value
- board_clear  input  1  wipe whole board
- clr_start  input  1  start line-clear sweep (level sampled, acted on in IDLE)
- busy  output  1  sweep in progress
- clr_done  output  1  one-cycle pulse at end of sweep
- lines_cleared  output  4  rows removed by last sweep

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - all cells 0
  - rd_data 0, busy 0, clr_done 0, lines_cleared 0
  - FSM in IDLE
- Read port:
  - rd_data <= cell[rd_y][rd_x] on every clk edge, so latency is exactly 1 cycle.
  - If rd_x >= COLS or rd_y >= ROWS, rd_data <= 0.
  - Reads are never blocked. During a sweep they return the current, possibly intermediate, array.
- Write port:
  - Active only in IDLE.
  - If wr_en=1 and the coordinates are in range, the cell updates at the clk edge.
  - Out-of-range writes are dropped.
  - Writes while busy=1 are dropped silently.
  - A read of the same cell in the cycle after a write returns the new value.
- FSM states: IDLE, SCAN, SHIFT, DONE. Row pointer r is 4 bits.
  - IDLE:
    - clr_start=1 -> SCAN with r = ROWS-1, lines_cleared <= 0, busy <= 1.
    - A write in the same cycle as clr_start is applied first and is visible to the scan.
  - SCAN:
    - Evaluates row r in one cycle. Row r is full when all COLS cells are nonzero.
    - Full -> SHIFT.
    - Not full and r > 0 -> r <= r-1, stay in SCAN.
    - Not full and r == 0 -> DONE.
  - SHIFT:
    - Single cycle: for every row k with 1 <= k <= r, row k <= row k-1; row 0 <= all zero.
    - lines_cleared <= lines_cleared + 1.
    - Return to SCAN with r unchanged, because the row that moved down must be rechecked.
  - DONE:
    - clr_done = 1 for exactly this cycle; busy <= 0; next state IDLE.
    - lines_cleared holds its value until the next clr_start.
- Sweep latency:
  - Empty board: ROWS SCAN cycles + 1 DONE cycle.
  - Each cleared row adds 2 cycles (1 SHIFT + 1 rescan).
- Full row 0: SHIFT zeroes it, the rescan finds it empty, then DONE.
- lines_cleared never exceeds ROWS.
- board_clear:
  - Has priority over writes, clr_start and the FSM.
  - All cells <= 0, FSM <= IDLE, busy <= 0, lines_cleared <= 0.
  - No clr_done pulse, including when asserted mid-sweep.
- rst mid-sweep: identical to the reset values above.

Optional Feature:
BOARD_TOTAL_LINES_EN
- Defined: adds output total_lines [15:0].
  - Increments by 1 in each SHIFT cycle and saturates at 16'hFFFF.
  - Cleared by rst and by board_clear.
  - Unchanged by clr_start.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Write (3,5)=2, then read (3,5) on the next cycle -> rd_data=2 one cycle after rd_x/rd_y are applied. Read (12,0) -> rd_data=0. Write to (10,9) -> no cell changes.
- Fill row 9 with 1s, set (4,8)=3, pulse clr_start -> busy=1 for 13 cycles (10 SCAN + 1 SHIFT + 1 rescan + 1 DONE), clr_done pulse, lines_cleared=1. Afterwards cell (4,9)=3, row 9 has no other nonzero cells, row 0 is all 0.
- Fill rows 9 and 7 fully, set (0,8)=1 -> lines_cleared=2, (0,9)=1, rows 0 and 1 are all 0.
- Fill row 0 only -> lines_cleared=1, board all 0, clr_done asserted in the cycle after the last SCAN.
- Start a sweep with 2 full rows and assert board_clear on the 3rd busy cycle -> next cycle busy=0, board all 0, lines_cleared=0, no clr_done. Separately: wr_en to (0,0)=3 while busy=1 -> (0,0) unchanged.
- With BOARD_TOTAL_LINES_EN defined: run two sweeps clearing 1 and then 3 rows -> total_lines=4. Assert rst -> total_lines=0.

Source files
------------

// File: rtl/board_mem.sv
// ---------------------------------------------------------------------------
// board_mem
//
// Purpose:
//   Cell-grid storage for the playfield: ROWS x COLS cells of CW bits each,
//   where a cell value of 0 means empty and any nonzero value is an occupied
//   cell carrying its colour. Game logic writes single cells, the pixel
//   generator reads one cell per pixel through a registered read port, and a
//   built-in line-clear engine removes every full row, drops the rows above
//   it and reports how many rows it removed.
//
//   Row 0 is the top of the playfield, row ROWS-1 the bottom. The sweep walks
//   from the bottom row upwards so that rows moving down are always rechecked
//   before the pointer moves past them.
//
// Ports:
//   i_clk             system clock
//   i_rst             synchronous active-high reset
//   i_wr_en           cell write strobe (honoured only while idle)
//   i_wr_x, i_wr_y    write column / row
//   i_wr_data         value to write
//   i_rd_x, i_rd_y    read column / row from the pixel generator
//   o_rd_data         registered cell value, one cycle after the address
//   i_board_clear     wipe the whole board and abort any sweep
//   i_clr_start       start a line-clear sweep (level sampled while idle)
//   o_busy            sweep in progress
//   o_clr_done        one-cycle pulse at the end of a sweep
//   o_lines_cleared   number of rows removed by the last sweep
//   o_total_lines     (BOARD_TOTAL_LINES_EN only) saturating lifetime count
//                     of removed rows
//
// Configuration:
//   Define BOARD_TOTAL_LINES_EN to add the o_total_lines port and counter.
//   Without it the block behaves identically, minus that port.
// ---------------------------------------------------------------------------
module board_mem #(
  parameter int COLS = 10,
  parameter int ROWS = 10,
  parameter int CW   = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [3:0]    i_wr_x,
  input  logic [3:0]    i_wr_y,
  input  logic [CW-1:0] i_wr_data,
  input  logic [3:0]    i_rd_x,
  input  logic [3:0]    i_rd_y,
  output logic [CW-1:0] o_rd_data,
  input  logic          i_board_clear,
  input  logic          i_clr_start,
  output logic          o_busy,
  output logic          o_clr_done,
  output logic [3:0]    o_lines_cleared
`ifdef BOARD_TOTAL_LINES_EN
  ,
  output logic [15:0]   o_total_lines
`endif
);

  // Coordinate limits narrowed to the 4-bit address width.
  localparam logic [3:0] LP_COLS     = 4'(COLS);
  localparam logic [3:0] LP_ROWS     = 4'(ROWS);
  localparam logic [3:0] LP_LAST_ROW = 4'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_SHIFT,
    S_DONE
  } state_t;

  // The board lives in flops: the sweep needs a whole row in parallel for
  // the full-row test and moves many rows at once in a single SHIFT cycle.
  logic [CW-1:0] r_cells [ROWS][COLS];

  state_t        r_state;
  logic [3:0]    r_row;
  logic          r_busy;
  logic          r_clrDone;
  logic [3:0]    r_linesCleared;
  logic [CW-1:0] r_rdData;

  logic          w_wrInRange;
  logic          w_rdInRange;
  logic          w_rowFull;

  assign w_wrInRange = (i_wr_x < LP_COLS) && (i_wr_y < LP_ROWS);
  assign w_rdInRange = (i_rd_x < LP_COLS) && (i_rd_y < LP_ROWS);

  // A row is full when none of its cells is empty. Only the row under the
  // sweep pointer is ever tested.
  always_comb begin
    w_rowFull = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (r_cells[r_row][c] == '0) begin
        w_rowFull = 1'b0;
      end
    end
  end

  // Read port: plain registered lookup of the current array, never stalled
  // by the sweep, so mid-sweep reads show the intermediate board. Addresses
  // outside the grid read as empty.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdData <= '0;
    end else if (w_rdInRange) begin
      r_rdData <= r_cells[i_rd_y][i_rd_x];
    end else begin
      r_rdData <= '0;
    end
  end

  // Board contents, sweep FSM and its registered status outputs.
  // board_clear sits just below reset so it overrides writes, clr_start and
  // whatever the sweep was doing, and deliberately produces no done pulse.
  // In IDLE a write and a clr_start in the same cycle both take effect at
  // the same edge, so the first SCAN cycle already sees the new cell.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_board_clear) begin
      for (int y = 0; y < ROWS; y++) begin
        for (int x = 0; x < COLS; x++) begin
          r_cells[y][x] <= '0;
        end
      end
      r_state        <= S_IDLE;
      r_row          <= '0;
      r_busy         <= 1'b0;
      r_clrDone      <= 1'b0;
      r_linesCleared <= '0;
    end else begin
      r_clrDone <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_wr_en && w_wrInRange) begin
            r_cells[i_wr_y][i_wr_x] <= i_wr_data;
          end
          if (i_clr_start) begin
            r_state        <= S_SCAN;
            r_row          <= LP_LAST_ROW;
            r_linesCleared <= '0;
            r_busy         <= 1'b1;
          end
        end

        // Full rows go to SHIFT without moving the pointer; otherwise the
        // pointer climbs until the top row has been checked. The done
        // pulse is registered here so it is high during the DONE cycle.
        S_SCAN: begin
          if (w_rowFull) begin
            r_state <= S_SHIFT;
          end else if (r_row != 4'd0) begin
            r_row <= r_row - 4'd1;
          end else begin
            r_state   <= S_DONE;
            r_clrDone <= 1'b1;
          end
        end

        // Drop every row at or above the pointer by one and feed an empty
        // row in at the top. The pointer stays put because the row that
        // just landed there has not been checked yet.
        S_SHIFT: begin
          for (int k = ROWS - 1; k >= 1; k--) begin
            if (4'(k) <= r_row) begin
              for (int x = 0; x < COLS; x++) begin
                r_cells[k][x] <= r_cells[k-1][x];
              end
            end
          end
          for (int x = 0; x < COLS; x++) begin
            r_cells[0][x] <= '0;
          end
          r_linesCleared <= r_linesCleared + 4'd1;
          r_state        <= S_SCAN;
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_rd_data       = r_rdData;
  assign o_busy          = r_busy;
  assign o_clr_done      = r_clrDone;
  assign o_lines_cleared = r_linesCleared;

`ifdef BOARD_TOTAL_LINES_EN
  logic [15:0] r_totalLines;

  // Lifetime count of removed rows: one per SHIFT cycle, sticking at the
  // top value instead of wrapping. Starting a sweep leaves it alone.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_board_clear) begin
      r_totalLines <= '0;
    end else if ((r_state == S_SHIFT) && (r_totalLines != 16'hFFFF)) begin
      r_totalLines <= r_totalLines + 16'd1;
    end
  end

  assign o_total_lines = r_totalLines;
`endif

endmodule

// File: tb/tb_board_mem.sv
// ---------------------------------------------------------------------------
// tb_board_mem
//
// Self-checking bench for board_mem. The expected board is kept as a plain
// integer array; a sweep is modelled by compacting all non-full rows towards
// the bottom and counting the rows that were dropped. Expected sweep length
// is ROWS scan cycles, one DONE cycle and two cycles per removed row.
// ---------------------------------------------------------------------------
module tb_board_mem;

  localparam int ROWS = 10;
  localparam int COLS = 10;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [3:0] wr_x;
  logic [3:0] wr_y;
  logic [1:0] wr_data;
  logic [3:0] rd_x;
  logic [3:0] rd_y;
  logic [1:0] rd_data;
  logic       board_clear;
  logic       clr_start;
  logic       busy;
  logic       clr_done;
  logic [3:0] lines_cleared;
`ifdef BOARD_TOTAL_LINES_EN
  logic [15:0] total_lines;
`endif

  int model [ROWS][COLS];
  int obs   [ROWS][COLS];
  int checks;
  int failures;

  board_mem #(.COLS(COLS), .ROWS(ROWS), .CW(2)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_wr_en         (wr_en),
    .i_wr_x          (wr_x),
    .i_wr_y          (wr_y),
    .i_wr_data       (wr_data),
    .i_rd_x          (rd_x),
    .i_rd_y          (rd_y),
    .o_rd_data       (rd_data),
    .i_board_clear   (board_clear),
    .i_clr_start     (clr_start),
    .o_busy          (busy),
    .o_clr_done      (clr_done),
    .o_lines_cleared (lines_cleared)
`ifdef BOARD_TOTAL_LINES_EN
    ,
    .o_total_lines   (total_lines)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic modelZero();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        model[y][x] = 0;
  endtask

  // Idle-time write through the port; the model drops out-of-range cells.
  task automatic writeCell(input int x, input int y, input int d);
    wr_x    = 4'(x);
    wr_y    = 4'(y);
    wr_data = 2'(d);
    wr_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    if (x < COLS && y < ROWS) model[y][x] = d;
  endtask

  task automatic fillRow(input int y, input int d);
    for (int x = 0; x < COLS; x++) writeCell(x, y, d);
  endtask

  task automatic clearAll();
    board_clear = 1'b1;
    tick();
    board_clear = 1'b0;
    modelZero();
  endtask

  // Read every cell through the read port into obs.
  task automatic readBoard();
    for (int y = 0; y < ROWS; y++) begin
      for (int x = 0; x < COLS; x++) begin
        rd_x = 4'(x);
        rd_y = 4'(y);
        tick();
        obs[y][x] = int'(rd_data);
      end
    end
  endtask

  // Reference sweep: keep non-full rows in order, stacked from the bottom.
  task automatic modelSweep(output int cleared);
    int  nxt [ROWS][COLS];
    int  dst;
    bit  full;
    cleared = 0;
    dst     = ROWS - 1;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        nxt[y][x] = 0;
    for (int y = ROWS - 1; y >= 0; y--) begin
      full = 1'b1;
      for (int x = 0; x < COLS; x++)
        if (model[y][x] == 0) full = 1'b0;
      if (full) begin
        cleared++;
      end else begin
        for (int x = 0; x < COLS; x++) nxt[dst][x] = model[y][x];
        dst--;
      end
    end
    model = nxt;
  endtask

  // Pulse clr_start and measure the sweep: busy cycles, done pulses, the
  // busy cycle the pulse fell in, and any stray pulse after busy drops.
  task automatic runSweep(output int nBusy, output int nDone,
                          output int doneIdx, output int lateDone);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    nBusy   = 0;
    nDone   = 0;
    doneIdx = -1;
    while (busy === 1'b1 && nBusy < 1000) begin
      nBusy++;
      if (clr_done === 1'b1) begin
        nDone++;
        doneIdx = nBusy;
      end
      tick();
    end
    lateDone = (clr_done === 1'b1) ? 1 : 0;
    tick();
    if (clr_done === 1'b1) lateDone = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if (rd_data !== 2'd0 || busy !== 1'b0 || clr_done !== 1'b0 || lines_cleared !== 4'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs rd=%0d busy=%0b done=%0b lines=%0d required all 0",
               rd_data, busy, clr_done, lines_cleared);
    end
    rst = 1'b0;
    modelZero();
    readBoard();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        checks++;
        if (obs[y][x] !== model[y][x]) begin
          failures++;
          $display("[TB] FAIL reset_cell(%0d,%0d) got %0d required %0d", x, y, obs[y][x], model[y][x]);
        end
      end
  endtask

  task automatic test_read_write();
    clearAll();
    writeCell(3, 5, 2);
    rd_x = 4'd3;
    rd_y = 4'd5;
    tick();
    checks++;
    if (rd_data !== 2'd2) begin
      failures++;
      $display("[TB] FAIL read_after_write got %0d required 2", rd_data);
    end
    // Write and read of the same cell at one edge: old value first, new next.
    writeCell(3, 5, 1);
    checks++;
    if (rd_data !== 2'd2) begin
      failures++;
      $display("[TB] FAIL read_same_edge got %0d required 2", rd_data);
    end
    tick();
    checks++;
    if (rd_data !== 2'd1) begin
      failures++;
      $display("[TB] FAIL read_latency got %0d required 1", rd_data);
    end
    writeCell(2, 0, 3);
    rd_x = 4'd12;
    rd_y = 4'd0;
    tick();
    checks++;
    if (rd_data !== 2'd0) begin
      failures++;
      $display("[TB] FAIL read_x_out_of_range got %0d required 0", rd_data);
    end
    rd_x = 4'd3;
    rd_y = 4'd10;
    tick();
    checks++;
    if (rd_data !== 2'd0) begin
      failures++;
      $display("[TB] FAIL read_y_out_of_range got %0d required 0", rd_data);
    end
    writeCell(10, 9, 3);
    writeCell(4, 12, 2);
    writeCell(15, 15, 1);
    readBoard();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        checks++;
        if (obs[y][x] !== model[y][x]) begin
          failures++;
          $display("[TB] FAIL oor_write_cell(%0d,%0d) got %0d required %0d", x, y, obs[y][x], model[y][x]);
        end
      end
  endtask

  task automatic test_sweep_single();
    int expCl, nBusy, nDone, doneIdx, lateDone;
    clearAll();
    fillRow(9, 1);
    writeCell(4, 8, 3);
    modelSweep(expCl);
    runSweep(nBusy, nDone, doneIdx, lateDone);
    checks++;
    if (nBusy !== 13) begin
      failures++;
      $display("[TB] FAIL single_busy_cycles got %0d required 13", nBusy);
    end
    checks++;
    if (nDone !== 1 || doneIdx !== nBusy || lateDone !== 0) begin
      failures++;
      $display("[TB] FAIL single_done_pulse pulses=%0d at=%0d late=%0d required 1 at %0d late 0",
               nDone, doneIdx, lateDone, nBusy);
    end
    checks++;
    if (int'(lines_cleared) !== expCl) begin
      failures++;
      $display("[TB] FAIL single_lines got %0d required %0d", lines_cleared, expCl);
    end
    readBoard();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        checks++;
        if (obs[y][x] !== model[y][x]) begin
          failures++;
          $display("[TB] FAIL single_cell(%0d,%0d) got %0d required %0d", x, y, obs[y][x], model[y][x]);
        end
      end
  endtask

  task automatic test_sweep_two();
    int expCl, nBusy, nDone, doneIdx, lateDone;
    clearAll();
    fillRow(9, 2);
    fillRow(7, 3);
    writeCell(0, 8, 1);
    modelSweep(expCl);
    runSweep(nBusy, nDone, doneIdx, lateDone);
    checks++;
    if (nBusy !== ROWS + 1 + 2 * expCl) begin
      failures++;
      $display("[TB] FAIL two_busy_cycles got %0d required %0d", nBusy, ROWS + 1 + 2 * expCl);
    end
    checks++;
    if (int'(lines_cleared) !== expCl || nDone !== 1) begin
      failures++;
      $display("[TB] FAIL two_lines got %0d pulses %0d required %0d pulses 1", lines_cleared, nDone, expCl);
    end
    readBoard();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        checks++;
        if (obs[y][x] !== model[y][x]) begin
          failures++;
          $display("[TB] FAIL two_cell(%0d,%0d) got %0d required %0d", x, y, obs[y][x], model[y][x]);
        end
      end
  endtask

  task automatic test_row0();
    int expCl, nBusy, nDone, doneIdx, lateDone;
    clearAll();
    fillRow(0, 3);
    modelSweep(expCl);
    runSweep(nBusy, nDone, doneIdx, lateDone);
    checks++;
    if (nBusy !== 13 || doneIdx !== 13 || nDone !== 1) begin
      failures++;
      $display("[TB] FAIL row0_timing busy=%0d done_at=%0d pulses=%0d required 13, 13, 1",
               nBusy, doneIdx, nDone);
    end
    checks++;
    if (int'(lines_cleared) !== expCl) begin
      failures++;
      $display("[TB] FAIL row0_lines got %0d required %0d", lines_cleared, expCl);
    end
    readBoard();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        checks++;
        if (obs[y][x] !== model[y][x]) begin
          failures++;
          $display("[TB] FAIL row0_cell(%0d,%0d) got %0d required %0d", x, y, obs[y][x], model[y][x]);
        end
      end
  endtask

  task automatic test_board_clear_mid();
    int sawDone;
    clearAll();
    fillRow(9, 1);
    fillRow(8, 2);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bclr_third_busy got %0b required 1", busy);
    end
    board_clear = 1'b1;
    tick();
    board_clear = 1'b0;
    modelZero();
    sawDone = (clr_done === 1'b1) ? 1 : 0;
    checks++;
    if (busy !== 1'b0 || lines_cleared !== 4'd0) begin
      failures++;
      $display("[TB] FAIL bclr_status busy=%0b lines=%0d required 0 0", busy, lines_cleared);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (clr_done === 1'b1 || busy === 1'b1) sawDone = 1;
    end
    checks++;
    if (sawDone !== 0) begin
      failures++;
      $display("[TB] FAIL bclr_no_done activity=%0d required 0", sawDone);
    end
    readBoard();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        checks++;
        if (obs[y][x] !== model[y][x]) begin
          failures++;
          $display("[TB] FAIL bclr_cell(%0d,%0d) got %0d required %0d", x, y, obs[y][x], model[y][x]);
        end
      end
  endtask

  task automatic test_reset_mid_sweep();
    clearAll();
    fillRow(9, 1);
    writeCell(5, 5, 2);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    modelZero();
    checks++;
    if (busy !== 1'b0 || clr_done !== 1'b0 || lines_cleared !== 4'd0 || rd_data !== 2'd0) begin
      failures++;
      $display("[TB] FAIL rst_mid busy=%0b done=%0b lines=%0d rd=%0d required all 0",
               busy, clr_done, lines_cleared, rd_data);
    end
    readBoard();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        checks++;
        if (obs[y][x] !== model[y][x]) begin
          failures++;
          $display("[TB] FAIL rst_mid_cell(%0d,%0d) got %0d required %0d", x, y, obs[y][x], model[y][x]);
        end
      end
  endtask

  task automatic test_write_while_busy();
    int expCl, n;
    clearAll();
    fillRow(5, 2);
    modelSweep(expCl);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    wr_x    = 4'd0;
    wr_y    = 4'd0;
    wr_data = 2'd3;
    wr_en   = 1'b1;
    tick();
    wr_x = 4'd0;
    wr_y = 4'd9;
    tick();
    tick();
    wr_en = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      tick();
    end
    checks++;
    if (n >= 1000 || int'(lines_cleared) !== expCl) begin
      failures++;
      $display("[TB] FAIL busy_write_sweep wait=%0d lines=%0d required done and %0d", n, lines_cleared, expCl);
    end
    readBoard();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        checks++;
        if (obs[y][x] !== model[y][x]) begin
          failures++;
          $display("[TB] FAIL busy_write_cell(%0d,%0d) got %0d required %0d", x, y, obs[y][x], model[y][x]);
        end
      end
  endtask

  task automatic test_random_sweeps();
    int expCl, nBusy, nDone, doneIdx, lateDone;
    bit full;
    int zc, v;
    for (int it = 0; it < 6; it++) begin
      clearAll();
      for (int y = 0; y < ROWS; y++) begin
        full = ($urandom_range(0, 2) == 0);
        zc   = int'($urandom_range(0, COLS - 1));
        for (int x = 0; x < COLS; x++) begin
          v = full ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
          if (!full && x == zc) v = 0;
          if (v != 0) writeCell(x, y, v);
        end
      end
      writeCell(int'($urandom_range(10, 15)), int'($urandom_range(0, 9)), 3);
      modelSweep(expCl);
      runSweep(nBusy, nDone, doneIdx, lateDone);
      checks++;
      if (nBusy !== ROWS + 1 + 2 * expCl || nDone !== 1 || doneIdx !== nBusy || lateDone !== 0) begin
        failures++;
        $display("[TB] FAIL rand%0d_timing busy=%0d pulses=%0d at=%0d late=%0d required busy %0d one pulse at end",
                 it, nBusy, nDone, doneIdx, lateDone, ROWS + 1 + 2 * expCl);
      end
      checks++;
      if (int'(lines_cleared) !== expCl) begin
        failures++;
        $display("[TB] FAIL rand%0d_lines got %0d required %0d", it, lines_cleared, expCl);
      end
      readBoard();
      for (int y = 0; y < ROWS; y++)
        for (int x = 0; x < COLS; x++) begin
          checks++;
          if (obs[y][x] !== model[y][x]) begin
            failures++;
            $display("[TB] FAIL rand%0d_cell(%0d,%0d) got %0d required %0d", it, x, y, obs[y][x], model[y][x]);
          end
        end
    end
  endtask

`ifdef BOARD_TOTAL_LINES_EN
  task automatic test_total_lines();
    int expCl, expTotal, nBusy, nDone, doneIdx, lateDone;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    modelZero();
    expTotal = 0;
    fillRow(9, 1);
    modelSweep(expCl);
    expTotal += expCl;
    runSweep(nBusy, nDone, doneIdx, lateDone);
    fillRow(9, 2);
    fillRow(8, 3);
    fillRow(6, 1);
    modelSweep(expCl);
    expTotal += expCl;
    runSweep(nBusy, nDone, doneIdx, lateDone);
    checks++;
    if (int'(total_lines) !== expTotal) begin
      failures++;
      $display("[TB] FAIL total_lines got %0d required %0d", total_lines, expTotal);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    modelZero();
    checks++;
    if (total_lines !== 16'd0) begin
      failures++;
      $display("[TB] FAIL total_after_rst got %0d required 0", total_lines);
    end
  endtask
`endif

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    wr_en       = 1'b0;
    wr_x        = '0;
    wr_y        = '0;
    wr_data     = '0;
    rd_x        = '0;
    rd_y        = '0;
    board_clear = 1'b0;
    clr_start   = 1'b0;
    tick();
    tick();
    test_reset();
    test_read_write();
    test_sweep_single();
    test_sweep_two();
    test_row0();
    test_board_clear_mid();
    test_reset_mid_sweep();
    test_write_while_busy();
    test_random_sweeps();
`ifdef BOARD_TOTAL_LINES_EN
    test_total_lines();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
